// File: rtl/sensor_response_framer.sv
// Buffers completed decoder answers in a small frame FIFO and streams each one
// to the UART transmitter as a two-byte frame: header (request code), then data.
module sensor_response_framer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finished,
  input  logic [7:0]       request,
  input  logic [7:0]       requested_data,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, HDR, HDR_ACK, DAT, DAT_ACK} state_t;

  state_t           state_q, state_d;
  logic             seen_low_q, seen_low_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             finished_q;
  logic             overflow_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] level_q;
  logic [15:0]      mem_q [DEPTH];

  logic        push, pop, full, empty, accept;
  logic [15:0] head;

  assign push   = finished & ~finished_q;
  assign full   = (level_q == CNT_W'(DEPTH));
  assign empty  = (level_q == '0);
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign accept = push & (~full | pop);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    seen_low_d = seen_low_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_ready) begin
          tx_data_d  = head[15:8];
          tx_start_d = 1'b1;
          state_d    = HDR;
        end
      end
      HDR: begin
        seen_low_d = 1'b0;
        state_d    = HDR_ACK;
      end
      HDR_ACK: begin
        // The entry stays at the head until its data byte launches.
        if (!seen_low_q) begin
          if (!tx_ready) seen_low_d = 1'b1;
        end else if (tx_ready && !empty) begin
          tx_data_d  = head[7:0];
          tx_start_d = 1'b1;
          pop        = 1'b1;
          seen_low_d = 1'b0;
          state_d    = DAT;
        end
      end
      DAT: begin
        seen_low_d = 1'b0;
        state_d    = DAT_ACK;
      end
      DAT_ACK: begin
        if (!seen_low_q) begin
          if (!tx_ready) seen_low_d = 1'b1;
        end else if (tx_ready) begin
          seen_low_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      seen_low_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      seen_low_q <= seen_low_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      finished_q <= finished;
      if (push && full && !pop) overflow_q <= 1'b1;
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({accept, pop})
        2'b10:   level_q <= level_q + CNT_W'(1);
        2'b01:   level_q <= level_q - CNT_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_ptr_q] <= {request, requested_data};
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
  assign busy       = (level_q != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_sensor_response_framer.sv
// Bench for sensor_response_framer: UART ready model, byte monitor with protocol
// checks, a vector table, directed corner sequences and a randomized frame run.
module tb_sensor_response_framer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset, finished, tx_ready, tx_start, busy, overflow;
  logic [7:0]       request, requested_data, tx_data;
  logic [CNT_W-1:0] fifo_level;

  sensor_response_framer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .finished(finished), .request(request),
    .requested_data(requested_data), .tx_ready(tx_ready), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0, proto_err = 0;
  logic [7:0] rx_q [$];
  bit manual = 0, man_ready = 0, hold = 0, rand_busy = 0;
  int busy_cfg = 10;

  typedef struct {
    logic [7:0] req, dat;
    int         hold_n, busyc;
    logic [7:0] exp_hdr, exp_dat;
    int         exp_peak;
  } vec_t;

  // Monitor + UART model, evaluated just after each falling edge.
  initial begin
    int cnt = 0;
    int rst_age = 9;
    bit prev_start = 0;
    logic [7:0] prev_data = 8'h00;
    tx_ready = 1'b1;
    forever begin
      @(negedge clock); #1;
      if (reset) rst_age = 0; else if (rst_age < 9) rst_age++;
      if (tx_start) rx_q.push_back(tx_data);
      if (tx_start && !tx_ready) begin
        proto_err++; $display("FAIL proto_start_not_ready at %0t", $time);
      end
      if (tx_start && prev_start) begin
        proto_err++; $display("FAIL proto_start_consecutive at %0t", $time);
      end
      if (rst_age > 1 && !tx_start && tx_data !== prev_data) begin
        proto_err++; $display("FAIL proto_data_changed got %0h was %0h at %0t", tx_data, prev_data, $time);
      end
      prev_start = tx_start;
      prev_data  = tx_data;
      if (manual) begin
        cnt = 0;
        tx_ready = man_ready;
      end else begin
        if (tx_start) cnt = rand_busy ? int'($urandom_range(2, 12)) : busy_cfg;
        else if (cnt > 0) cnt--;
        tx_ready = (cnt == 0) && !hold;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int t = 0;
    while (rx_q.size() < target && t < budget) begin tick(); t++; end
    check(name, 32'(rx_q.size() >= target), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy && t < budget) begin tick(); t++; end
    check(name, 32'(busy), 0);
  endtask

  task automatic capture(input logic [7:0] r, input logic [7:0] d, input int hold_n);
    request = r; requested_data = d; finished = 1'b1;
    tick(hold_n);
    finished = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0; tick();
  endtask

  initial begin
    vec_t tbl [5];
    logic [15:0] exp_q [$];
    int base, peak, accepted, t;
    logic [7:0] r, d;

    tbl[0] = '{8'h01, 8'h19, 1,  10, 8'h01, 8'h19, 1};
    tbl[1] = '{8'h03, 8'h2A, 20, 10, 8'h03, 8'h2A, 1};
    tbl[2] = '{8'h01, 8'h10, 1,  10, 8'h01, 8'h10, 1};
    tbl[3] = '{8'hFF, 8'h00, 3,  4,  8'hFF, 8'h00, 1};
    tbl[4] = '{8'h00, 8'hFF, 2,  2,  8'h00, 8'hFF, 1};

    reset = 1'b1; finished = 1'b0; request = 8'h00; requested_data = 8'h00;
    tick(3);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(fifo_level), 0);
    reset = 1'b0; tick();

    // First frame: capture/launch latency and level around the data pop.
    request = 8'h01; requested_data = 8'h19; finished = 1'b1;
    tick();
    check("lat_level_after_capture", 32'(fifo_level), 1);
    check("lat_no_start_yet", 32'(tx_start), 0);
    finished = 1'b0;
    tick();
    check("lat_hdr_start", 32'(tx_start), 1);
    check("lat_hdr_data", 32'(tx_data), 8'h01);
    base = rx_q.size();
    wait_rx(base + 1, 20, "lat_hdr_seen");
    tick();
    check("lat_level_before_pop", 32'(fifo_level), 1);
    wait_rx(base + 2, 60, "lat_dat_seen");
    tick();
    check("lat_level_after_pop", 32'(fifo_level), 0);
    check("lat_busy_in_dat_ack", 32'(busy), 1);
    wait_idle(60, "lat_busy_drops");
    check("lat_frame", {rx_q[base], rx_q[base+1]}, 16'h0119);

    foreach (tbl[i]) begin
      busy_cfg = tbl[i].busyc;
      base = rx_q.size(); peak = 0;
      request = tbl[i].req; requested_data = tbl[i].dat; finished = 1'b1;
      for (int c = 0; c < tbl[i].hold_n; c++) begin
        tick(); if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      finished = 1'b0;
      t = 0;
      while (rx_q.size() < base + 2 && t < 200) begin
        tick(); t++; if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      wait_idle(100, $sformatf("vec%0d_idle", i));
      tick(15);
      check($sformatf("vec%0d_count", i), rx_q.size(), base + 2);
      check($sformatf("vec%0d_frame", i), {rx_q[base], rx_q[base+1]}, {tbl[i].exp_hdr, tbl[i].exp_dat});
      check($sformatf("vec%0d_peak", i), peak, tbl[i].exp_peak);
    end
    busy_cfg = 10;

    // Overflow: five captures while the UART stays busy.
    hold = 1; tick(2);
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin capture(8'h05, 8'hA0 + 8'(i), 1); tick(); end
    check("ovf_level_full", 32'(fifo_level), DEPTH);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_nothing_sent", rx_q.size(), base);
    hold = 0;
    wait_rx(base + 8, 300, "ovf_drain");
    wait_idle(100, "ovf_idle");
    tick(20);
    check("ovf_count", rx_q.size(), base + 8);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_frame%0d", i), {rx_q[base+2*i], rx_q[base+2*i+1]}, {8'h05, 8'hA0 + 8'(i)});
    check("ovf_sticky", 32'(overflow), 1);

    do_reset();
    check("ovf_cleared_by_reset", 32'(overflow), 0);

    // Full FIFO with a capture on the very edge the head's data byte pops.
    manual = 1; man_ready = 0; tick(2);
    base = rx_q.size();
    for (int i = 0; i < 4; i++) begin capture(8'h07, 8'hB0 + 8'(i), 1); tick(); end
    check("fp_level_full", 32'(fifo_level), DEPTH);
    man_ready = 1; tick();
    check("fp_hdr_start", 32'(tx_start), 1);
    check("fp_hdr_data", 32'(tx_data), 8'h07);
    tick();
    man_ready = 0; tick();
    man_ready = 1; request = 8'h07; requested_data = 8'hC4; finished = 1'b1;
    tick();
    check("fp_dat_start", 32'(tx_start), 1);
    check("fp_dat_data", 32'(tx_data), 8'hB0);
    check("fp_level_kept", 32'(fifo_level), DEPTH);
    check("fp_no_overflow", 32'(overflow), 0);
    finished = 1'b0; tick();
    man_ready = 0; tick();
    man_ready = 1; manual = 0;
    wait_rx(base + 10, 400, "fp_drain");
    wait_idle(100, "fp_idle");
    tick(20);
    check("fp_count", rx_q.size(), base + 10);
    for (int i = 0; i < 5; i++)
      check($sformatf("fp_frame%0d", i), {rx_q[base+2*i], rx_q[base+2*i+1]},
            {8'h07, (i < 4) ? 8'hB0 + 8'(i) : 8'hC4});
    check("fp_overflow_end", 32'(overflow), 0);

    // Reset while waiting for the header acknowledge with two frames queued.
    manual = 1; man_ready = 0; tick(2);
    capture(8'h09, 8'hD0, 1); tick();
    capture(8'h09, 8'hD1, 1); tick();
    check("ra_level_two", 32'(fifo_level), 2);
    man_ready = 1; tick();
    check("ra_hdr_start", 32'(tx_start), 1);
    tick();
    man_ready = 0; tick();
    reset = 1'b1; tick();
    check("ra_tx_start", 32'(tx_start), 0);
    check("ra_tx_data", 32'(tx_data), 0);
    check("ra_busy", 32'(busy), 0);
    check("ra_level", 32'(fifo_level), 0);
    check("ra_overflow", 32'(overflow), 0);
    reset = 1'b0; man_ready = 1;
    base = rx_q.size();
    tick(30);
    check("ra_silent", rx_q.size(), base);
    manual = 0; tick();
    capture(8'h01, 8'h10, 1);
    wait_rx(base + 2, 60, "ra_new_frame");
    check("ra_err_frame", {rx_q[base], rx_q[base+1]}, 16'h0110);
    wait_idle(60, "ra_idle");

    // Randomized frames; captures are spaced so the FIFO never overflows.
    do_reset();
    rand_busy = 1; accepted = 0;
    base = rx_q.size();
    for (int f = 0; f < 40; f++) begin
      tick(int'($urandom_range(1, 10)));
      t = 0;
      while ((accepted - (rx_q.size() - base) / 2) >= DEPTH && t < 500) begin tick(); t++; end
      check($sformatf("rnd_space%0d", f), 32'(t < 500), 1);
      r = 8'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
      capture(r, d, int'($urandom_range(1, 4)));
      exp_q.push_back({r, d});
      accepted++;
    end
    wait_rx(base + 80, 4000, "rnd_drain");
    wait_idle(100, "rnd_idle");
    tick(20);
    check("rnd_count", rx_q.size(), base + 80);
    for (int f = 0; f < 40; f++)
      if (rx_q.size() >= base + 2*f + 2)
        check($sformatf("rnd_frame%0d", f), {rx_q[base+2*f], rx_q[base+2*f+1]}, exp_q[f]);
    check("rnd_overflow", 32'(overflow), 0);
    check("rnd_level", 32'(fifo_level), 0);

    check("protocol_violations", proto_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
